muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 64-bit multiply / divide unit.
//   Multiply: radix-2 shift-add, one step per cycle, 128-bit product.
//   Divide:   restoring shift-subtract, one step per cycle.
//   Signed operands are reduced to magnitudes on accept; the sign fix-up is
//   applied on the CALC->DONE edge.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   muldiv_rs1_data_i/_sign  operand A (multiplicand / dividend) and its sign flag
//   muldiv_rs2_data_i/_sign  operand B (multiplier / divisor) and its sign flag
//   muldiv_mul_en_i          1 = multiply, 0 = divide
//   muldiv_req_valid_i       request level, held until done
//   flush_i                  abort; back to IDLE with no done pulse
//   muldiv_busy_o            operation in flight (combinational in IDLE)
//   muldiv_done_o            one-cycle result-valid pulse
//   muldiv_data_1_o/_2_o     product lo/hi, or quotient/remainder
//
// Configuration
//   MULDIV_ZERO_SKIP_EN  when defined, a multiply finishes as soon as the
//                        remaining multiplier bits are all zero.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] muldiv_rs1_data_i,
  input  logic [63:0] muldiv_rs2_data_i,
  input  logic        muldiv_rs1_sign_i,
  input  logic        muldiv_rs2_sign_i,
  input  logic        muldiv_mul_en_i,
  input  logic        muldiv_req_valid_i,
  input  logic        flush_i,
  output logic        muldiv_busy_o,
  output logic        muldiv_done_o,
  output logic [63:0] muldiv_data_1_o,
  output logic [63:0] muldiv_data_2_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic           mul_q, mul_d;
  logic           a_neg_q, a_neg_d;
  logic           b_neg_q, b_neg_d;
  // acc: product accumulator (mul) or partial remainder in [63:0] (div)
  // sh:  shifted multiplicand (mul) or dividend/quotient in [63:0] (div)
  // opb: remaining multiplier bits (mul) or divisor magnitude (div)
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   sh_q, sh_d;
  logic [63:0]    opb_q, opb_d;
  logic [63:0]    data_1_q, data_1_d;
  logic [63:0]    data_2_q, data_2_d;

  // operand decode on the request inputs
  logic        a_neg, b_neg, div0, ovf;
  logic [63:0] a_mag, b_mag;

  assign a_neg = muldiv_rs1_sign_i & muldiv_rs1_data_i[63];
  assign b_neg = muldiv_rs2_sign_i & muldiv_rs2_data_i[63];
  assign a_mag = a_neg ? (~muldiv_rs1_data_i + 64'd1) : muldiv_rs1_data_i;
  assign b_mag = b_neg ? (~muldiv_rs2_data_i + 64'd1) : muldiv_rs2_data_i;
  assign div0  = (muldiv_rs2_data_i == 64'd0);
  assign ovf   = muldiv_rs1_sign_i & muldiv_rs2_sign_i &
                 (muldiv_rs1_data_i == 64'h8000_0000_0000_0000) &
                 (muldiv_rs2_data_i == 64'hFFFF_FFFF_FFFF_FFFF);

  // datapath for one iteration
  logic [127:0] mul_sum;
  logic [64:0]  rem_sh;
  logic         div_ge;
  logic [63:0]  rem_sub;
  logic [127:0] prod_fix;
  logic [63:0]  quo_fix, rem_fix;
  logic         calc_last;

  assign mul_sum = acc_q + (opb_q[0] ? sh_q : 128'd0);
  assign rem_sh  = {acc_q[63:0], sh_q[63]};
  assign div_ge  = (rem_sh >= {1'b0, opb_q});
  // when div_ge holds the true difference is below the divisor, so 64 bits suffice
  assign rem_sub = rem_sh[63:0] - opb_q;

  assign prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + 128'd1) : acc_q;
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? (~sh_q[63:0] + 64'd1) : sh_q[63:0];
  assign rem_fix  = a_neg_q ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];

`ifdef MULDIV_ZERO_SKIP_EN
  assign calc_last = (cnt_q == 7'd64) | (mul_q & (opb_q == 64'd0));
`else
  assign calc_last = (cnt_q == 7'd64);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opb_d    = opb_q;
    data_1_d = data_1_q;
    data_2_d = data_2_q;

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (muldiv_req_valid_i) begin
            mul_d   = muldiv_mul_en_i;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            cnt_d   = 7'd0;
            acc_d   = 128'd0;
            sh_d    = {64'd0, a_mag};
            opb_d   = b_mag;
            if (!muldiv_mul_en_i && div0) begin
              data_1_d = 64'hFFFF_FFFF_FFFF_FFFF;
              data_2_d = muldiv_rs1_data_i;
              state_d  = DONE;
            end else if (!muldiv_mul_en_i && ovf) begin
              data_1_d = muldiv_rs1_data_i;
              data_2_d = 64'd0;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (calc_last) begin
            state_d = DONE;
            if (mul_q) begin
              data_1_d = prod_fix[63:0];
              data_2_d = prod_fix[127:64];
            end else begin
              data_1_d = quo_fix;
              data_2_d = rem_fix;
            end
          end else begin
            cnt_d = cnt_q + 7'd1;
            if (mul_q) begin
              acc_d = mul_sum;
              sh_d  = {sh_q[126:0], 1'b0};
              opb_d = {1'b0, opb_q[63:1]};
            end else begin
              acc_d = {64'd0, div_ge ? rem_sub : rem_sh[63:0]};
              sh_d  = {64'd0, sh_q[62:0], div_ge};
            end
          end
        end
        // the requester advances during DONE, so never re-accept here
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      mul_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      acc_q    <= 128'd0;
      sh_q     <= 128'd0;
      opb_q    <= 64'd0;
      data_1_q <= 64'd0;
      data_2_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opb_q    <= opb_d;
      data_1_q <= data_1_d;
      data_2_q <= data_2_d;
    end
  end

  assign muldiv_busy_o   = (state_q == CALC) | ((state_q == IDLE) & muldiv_req_valid_i);
  assign muldiv_done_o   = (state_q == DONE);
  assign muldiv_data_1_o = data_1_q;
  assign muldiv_data_2_o = data_2_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rs1, rs2;
  logic        s1, s2, mul_en, req, flush;
  logic        busy, done;
  logic [63:0] d1, d2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] last_d1, last_d2;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk                (clk),
    .rst                (rst),
    .muldiv_rs1_data_i  (rs1),
    .muldiv_rs2_data_i  (rs2),
    .muldiv_rs1_sign_i  (s1),
    .muldiv_rs2_sign_i  (s2),
    .muldiv_mul_en_i    (mul_en),
    .muldiv_req_valid_i (req),
    .flush_i            (flush),
    .muldiv_busy_o      (busy),
    .muldiv_done_o      (done),
    .muldiv_data_1_o    (d1),
    .muldiv_data_2_o    (d2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on sign-extended operands.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic sa, input logic sb, input logic mul,
                                output logic [63:0] e1, output logic [63:0] e2,
                                output int lat);
    logic [127:0]       ea, eb, p;
    logic signed [64:0] xa, xb, q, r;
`ifdef MULDIV_ZERO_SKIP_EN
    logic [63:0]        bm;
`endif
    if (mul) begin
      ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
      eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      e1 = p[63:0];
      e2 = p[127:64];
`ifdef MULDIV_ZERO_SKIP_EN
      bm  = (sb && b[63]) ? (64'd0 - b) : b;
      lat = 1;
      for (int i = 0; i < 64; i++) if (bm[i]) lat = i + 2;
`else
      lat = 65;
`endif
    end else if (b == 64'd0) begin
      e1 = ONES; e2 = a; lat = 0;
    end else if (sa && sb && a == MINS && b == ONES) begin
      e1 = a; e2 = 64'd0; lat = 0;
    end else begin
      xa  = sa ? {a[63], a} : {1'b0, a};
      xb  = sb ? {b[63], b} : {1'b0, b};
      q   = xa / xb;
      r   = xa % xb;
      e1  = q[63:0];
      e2  = r[63:0];
      lat = 65;
    end
  endfunction

  // One full handshake; chk_x adds explicit expected values for directed cases.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sa, input logic sb, input logic mul,
                        input logic chk_x, input logic [63:0] x1, input logic [63:0] x2);
    logic [63:0] e1, e2;
    int elat, lat;
    model(a, b, sa, sb, mul, e1, e2, elat);
    @(negedge clk);
    rs1 = a; rs2 = b; s1 = sa; s2 = sb; mul_en = mul; req = 1'b1;
    #1 chk({tag, ".busy_req"}, busy, 1);
    @(posedge clk); #1;
    // operands must be ignored after accept
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
    s1 = 1'($urandom); s2 = 1'($urandom); mul_en = 1'($urandom);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".d1"}, d1, e1);
    chk({tag, ".d2"}, d2, e2);
    if (chk_x) begin
      chk({tag, ".d1_exp"}, d1, x1);
      chk({tag, ".d2_exp"}, d2, x2);
    end
    chk({tag, ".busy_done"}, busy, 0);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse"}, done, 0);
    chk({tag, ".hold"}, {d2, d1}, {e2, e1});
    last_d1 = e1;
    last_d2 = e2;
  endtask

  initial begin
    int dones;
    logic [63:0] a, b;
    rst = 1'b0; rs1 = '0; rs2 = '0; s1 = 0; s2 = 0; mul_en = 0; req = 0; flush = 0;
    #12;
    chk("rst.d1", d1, 0);
    chk("rst.d2", d2, 0);
    chk("rst.done", done, 0);
    @(negedge clk) rst = 1'b1;

    run_op("umul_ones_x2", ONES, 64'd2, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    run_op("smul_m3_x7", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFEB, ONES);
    run_op("sdiv_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, ONES);
    run_op("udiv_100_7", 64'd100, 64'd7, 0, 0, 0, 1, 64'd14, 64'd2);
    run_op("div0", 64'd5, 64'd0, 0, 0, 0, 1, ONES, 64'd5);
    run_op("sdiv_ovf", MINS, ONES, 1, 1, 0, 1, MINS, 64'd0);
    run_op("mul_9x1", 64'd9, 64'd1, 0, 0, 1, 1, 64'd9, 64'd0);
    run_op("mul_x0", 64'd1234, 64'd0, 1, 1, 1, 1, 64'd0, 64'd0);

    // flush mid-multiply, with the request still raised (flush beats accept)
    @(negedge clk);
    rs1 = {$urandom, $urandom}; rs2 = {1'b1, 31'($urandom), 32'($urandom)};
    s1 = 0; s2 = 0; mul_en = 1; req = 1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.done", done, 0);
    @(negedge clk) begin flush = 1'b0; req = 1'b0; end
    dones = 0;
    repeat (70) begin @(posedge clk); #1; if (done) dones++; end
    chk("flush.no_done", dones, 0);
    chk("flush.hold", {d2, d1}, {last_d2, last_d1});
    chk("flush.idle_busy", busy, 0);
    run_op("post_flush", 64'd123456789, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1, 1, 0, 0, 0);

    // reset during a divide at step 10
    @(negedge clk);
    rs1 = 64'd100; rs2 = 64'd7; s1 = 0; s2 = 0; mul_en = 0; req = 1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst.d1", d1, 0);
    chk("mid_rst.d2", d2, 0);
    chk("mid_rst.done", done, 0);
    @(negedge clk) req = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    // run_op presents the request on the next negedge: first edge after release
    run_op("post_rst", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 0, 0, 0, 0, 0);
    dones = 0;
    repeat (5) begin @(posedge clk); #1; if (done) dones++; end
    chk("post_rst.idle", dones, 0);

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 15));
        2: b = ONES;
        3: b = {$urandom, $urandom};
        4: b = {$urandom, $urandom} >> $urandom_range(0, 63);
        5: begin a = MINS; b = ONES; end
        default: b = 64'd0 - 64'($urandom_range(1, 9));
      endcase
      run_op($sformatf("rnd%0d", i), a, b, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
